inst_fetch_if: RTL
==================

# inst_fetch_if

Instruction-fetch bus interface between the PC register and the IF/ID pipeline register. Takes the current `pc`/`ce`, issues one read per instruction on the instruction bus, and holds the pipeline through a stall request while the bus is busy. It presents the fetched word to IF/ID and keeps that word stable across pipeline stalls. It also handles flush aborts and flags bus time-outs.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles waiting for `ibus_ack_i` before the fetch is abandoned; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  6  pipeline stall vector from the stall controller; bit 1 = IF/ID stage held.
- `flush`  in  1  pipeline flush (exception/eret); abandons any fetch in progress.
- `pc_i`  in  32  fetch address from the PC register.
- `ce_i`  in  1  fetch enable from the PC register.
- `inst_o`  out  32  instruction word to IF/ID.
- `stallreq_o`  out  1  stall request to the stall controller while a fetch is outstanding.
- `ibus_req_o`  out  1  bus read request, registered.
- `ibus_addr_o`  out  32  bus read address, registered.
- `ibus_ack_i`  in  1  read data valid; sampled only while `ibus_req_o`=1.
- `ibus_rdata_i`  in  32  read data, valid when `ibus_ack_i`=1.
- `ibus_err_o`  out  1  sticky time-out flag; cleared only by `rst`.

## Operation
- FSM has 3 states: `IDLE`, `BUSY`, `HOLD`.
- Registered state: `state`, `ibus_req_o`, `ibus_addr_o`, `rd_buf` (32), `wait_cnt` (8), `ibus_err_o`.
- `stallreq_o` and `inst_o` are combinational from state and inputs.

`IDLE`:
- `stallreq_o` = `ce_i & ~flush`.
- `inst_o` = 0.
- If `ce_i & ~flush`: `ibus_req_o`<=1, `ibus_addr_o`<=`pc_i`, `wait_cnt`<=0, go to `BUSY`.

`BUSY`:
- `stallreq_o` = `~ibus_ack_i & ~flush`.
- `inst_o` = `ibus_ack_i ? ibus_rdata_i : 0`.
- Event priority: flush > ack > timeout.
- `flush`: `ibus_req_o`<=0, `rd_buf`<=0, go to `IDLE`. Any ack in the same cycle is ignored. Deasserting `req` before ack is a legal abort on this bus.
- `ibus_ack_i`: `ibus_req_o`<=0, `rd_buf`<=`ibus_rdata_i`. If `stall` != 0, go to `HOLD`; otherwise go to `IDLE`.
- Otherwise `wait_cnt`<=`wait_cnt`+1. When `wait_cnt`==`TIMEOUT`-1 and no ack: `ibus_req_o`<=0, `ibus_err_o`<=1, `rd_buf`<=0 (NOP), `stallreq_o`=0 that cycle, `inst_o`=0, go to `IDLE`.
- `wait_cnt` saturates; it never wraps.

`HOLD`:
- `stallreq_o` = 0.
- `inst_o` = `rd_buf`.
- `flush`: `rd_buf`<=0, go to `IDLE`.
- Else if `stall` == 0: go to `IDLE`.

General rules:
- `ibus_addr_o` changes only on the `IDLE`->`BUSY` transition.
- The low two bits of `pc_i` are passed through unchanged; alignment is the bus's concern.

## Timing
- Reset values: `state`=`IDLE`, `ibus_req_o`=0, `ibus_addr_o`=0, `rd_buf`=0, `wait_cnt`=0, `ibus_err_o`=0. This gives `stallreq_o`=0 and `inst_o`=0 while `rst`=1, irrespective of `ce_i`.
- Reset mid-fetch drops `ibus_req_o` on the next edge; a late ack is ignored.
- Issue: `ibus_req_o` rises 1 cycle after `ce_i` is seen in `IDLE`.
- Minimum fetch: ack in the first `BUSY` cycle, giving 2 cycles per instruction. `stallreq_o` is high for exactly 1 cycle (the `IDLE` cycle).
- An ack N cycles into `BUSY` gives N+1 stall cycles.
- `inst_o` equals `ibus_rdata_i` in the ack cycle, so IF/ID captures it at that edge if `stall[1]`=0.
- `PC register` advances only when `stall[0]`=0, which happens on the ack cycle; the next fetch uses pc+4.
- Back-to-back fetches: `ack` then `IDLE` then `req` gives 1 idle bus cycle between requests.

## Structure
- Add to the shared define package: state encodings `IF_IDLE`=2'b00, `IF_BUSY`=2'b01, `IF_HOLD`=2'b10, and `IbusTimeoutDefault`=8'd255.
- Reuse the existing `ZeroWord`, `RstEnable`, `InstAddrBus`, `InstBus` and `NoStop` macros.
- No sub-module; single FSM plus counter.

## Test plan
- Zero-wait fetch: `ce_i`=1, `pc_i`=0x0, bus acks in the first `BUSY` cycle with 0x3C010001 -> `ibus_addr_o`=0x0, `inst_o`=0x3C010001 on the ack cycle, `stallreq_o` pattern 1,0.
- Wait states: ack 3 cycles after `req` rises with 0x34210020 -> `stallreq_o` high 4 consecutive cycles, `ibus_addr_o` stable at 0x4 throughout.
- Stall hold: ack 0xAC010000 while `stall`=6'b000011 for 3 cycles -> `inst_o`=0xAC010000 in all 3 `HOLD` cycles, `stallreq_o`=0, then `IDLE`.
- Flush abort: `flush`=1 in the second `BUSY` cycle, simultaneous with ack data 0xDEADBEEF -> `ibus_req_o`=0 next cycle, `inst_o`=0, no `HOLD` entry.
- Time-out: `TIMEOUT`=4, never ack -> `ibus_req_o` drops after 4 `BUSY` cycles, `ibus_err_o`=1 and stays 1, `inst_o`=0.
- Reset mid-fetch: `rst`=1 during `BUSY` -> next edge `ibus_req_o`=0, `state`=`IDLE`, `stallreq_o`=0; a late ack 1 cycle later is ignored.

Source files
------------

// File: rtl/inst_fetch_if_pkg.sv
// inst_fetch_if_pkg: shared fetch-interface encodings and bus-width constants.
package inst_fetch_if_pkg;
  localparam logic [1:0] IF_IDLE = 2'b00;
  localparam logic [1:0] IF_BUSY = 2'b01;
  localparam logic [1:0] IF_HOLD = 2'b10;
  localparam logic [7:0] IbusTimeoutDefault = 8'd255;
  localparam logic RstEnable = 1'b1;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;
  localparam logic [5:0] NoStop = 6'b000000;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: one-read-per-instruction fetch bus master with stall hold, flush abort and time-out.
module inst_fetch_if
  import inst_fetch_if_pkg::*;
#(
  parameter int TIMEOUT = int'(IbusTimeoutDefault)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   ce_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   stallreq_o,
  output logic                   ibus_req_o,
  output logic [InstAddrBus-1:0] ibus_addr_o,
  input  logic                   ibus_ack_i,
  input  logic [InstBus-1:0]     ibus_rdata_i,
  output logic                   ibus_err_o
);
  localparam logic [7:0] WaitMax = 8'(TIMEOUT - 1);
  logic [1:0]         state;
  logic [InstBus-1:0] rd_buf;
  logic [7:0]         wait_cnt;
  logic               start, ack, timed_out;
  assign start = (state == IF_IDLE) & ce_i & ~flush;
  assign ack = (state == IF_BUSY) & ibus_ack_i & ~flush;
  // time-out fires only when neither flush nor ack claims the cycle
  assign timed_out = (state == IF_BUSY) & ~flush & ~ibus_ack_i & (wait_cnt == WaitMax);
  always_comb begin
    stallreq_o = 1'b0;
    inst_o = ZeroWord;
    if (rst != RstEnable) begin
      stallreq_o = (state == IF_IDLE) ? start :
                   (state == IF_BUSY) ? ~ibus_ack_i & ~flush & ~timed_out : 1'b0;
      inst_o = (state == IF_BUSY) ? (ibus_ack_i ? ibus_rdata_i : ZeroWord) :
               (state == IF_HOLD) ? rd_buf : ZeroWord;
    end
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state       <= IF_IDLE;
      ibus_req_o  <= 1'b0;
      ibus_addr_o <= '0;
      rd_buf      <= ZeroWord;
      wait_cnt    <= '0;
      ibus_err_o  <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: if (start) begin
          ibus_req_o  <= 1'b1;
          ibus_addr_o <= pc_i;
          wait_cnt    <= '0;
          state       <= IF_BUSY;
        end
        IF_BUSY: if (flush) begin
          ibus_req_o <= 1'b0;
          rd_buf     <= ZeroWord;
          state      <= IF_IDLE;
        end else if (ack) begin
          ibus_req_o <= 1'b0;
          rd_buf     <= ibus_rdata_i;
          state      <= (stall != NoStop) ? IF_HOLD : IF_IDLE;
        end else begin
          wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
          if (timed_out) begin
            ibus_req_o <= 1'b0;
            ibus_err_o <= 1'b1;
            rd_buf     <= ZeroWord;
            state      <= IF_IDLE;
          end
        end
        IF_HOLD: if (flush) begin
          rd_buf <= ZeroWord;
          state  <= IF_IDLE;
        end else if (stall == NoStop) begin
          state <= IF_IDLE;
        end
        default: state <= IF_IDLE;
      endcase
    end
  end
endmodule
